// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
// Holds the frame shape, the default bit period and the receiver FSM states.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;
    localparam int DATA_BITS            = 8;
    localparam int START_BITS           = 1;
    localparam int STOP_BITS            = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops reset to RST_VAL so an idle line does not look like an edge.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/receiver_uart.sv
// 8N1 UART receiver: samples each bit mid-period using a bit-timer,
// reports good frames with valid and bad stop bits with frame_err.
module receiver_uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int             TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  HALF_LAST = TW'(HALF_BIT - 1);
    localparam logic [2:0]     IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rxs;
    uart_state_t          state;
    logic [TW-1:0]        timer;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shreg;

    uart_sync #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (RxD),
        .q  (rxs)
    );

    // NOTE: every register here is updated with <= so all branches see the
    // pre-edge values; the pulses default low so each lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (!rxs) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        if (!rxs) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        // Index holds at its last value instead of wrapping.
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (rxs) begin
                            data  <= shreg;
                            valid <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    timer <= '0;
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receiver_uart.sv
// Directed bench for receiver_uart at 16 clocks per bit; a negedge monitor
// pops expected bytes from a scoreboard queue whenever valid pulses.
module tb_receiver_uart;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         fall_cyc = 0;
    int         last_valid_cyc = 0;
    logic [7:0] exp_q[$];

    receiver_uart #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RxD      (rxd),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (valid === 1'b1 || frame_err === 1'b1) begin
                n_cmp++;
                if (valid === 1'b1 && frame_err === 1'b1) begin
                    n_bad++;
                    $display("FAIL pulse_overlap: valid=%b frame_err=%b, required not both high", valid, frame_err);
                end
            end
            if (valid === 1'b1) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_valid: data=%h, no frame expected", data);
                end else begin
                    logic [7:0] exp;
                    exp = exp_q.pop_front();
                    if (data !== exp) begin
                        n_bad++;
                        $display("FAIL rx_data: got %h, required %h", data, exp);
                    end
                end
            end
            if (frame_err === 1'b1) ferr_cnt++;
        end
    end

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input int period, input logic stop_val);
        @(posedge clk);
        #1;
        fall_cyc = cyc;
        drive_bit(1'b0, period);
        for (int i = 0; i < 8; i++) drive_bit(b[i], period);
        drive_bit(stop_val, period);
    endtask

    task automatic wait_drain(output int left);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        left = exp_q.size();
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (data !== 8'h00)    begin n_bad++; $display("FAIL reset_data: got %h, required 00", data); end
        n_cmp++; if (valid !== 1'b0)    begin n_bad++; $display("FAIL reset_valid: got %b, required 0", valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL idle_busy: got %b, required 0", busy); end
    endtask

    task automatic test_good_frame();
        int left, f0, v0, lat;
        f0 = ferr_cnt;
        v0 = valid_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, CPB, 1'b1);
        wait_drain(left);
        n_cmp++; if (left != 0) begin n_bad++; $display("FAIL good_pending: %0d frames outstanding, required 0", left); end
        n_cmp++; if (valid_cnt - v0 != 1) begin n_bad++; $display("FAIL good_valid_count: got %0d, required 1", valid_cnt - v0); end
        lat = last_valid_cyc - fall_cyc;
        n_cmp++; if (lat < 1 + 8 + 9 * CPB || lat > 3 + 8 + 9 * CPB) begin
            n_bad++; $display("FAIL good_latency: got %0d cycles, required %0d..%0d", lat, 1 + 8 + 9 * CPB, 3 + 8 + 9 * CPB);
        end
        n_cmp++; if (ferr_cnt != f0) begin n_bad++; $display("FAIL good_frame_err: got %0d pulses, required 0", ferr_cnt - f0); end
        n_cmp++; if (data !== 8'hA5) begin n_bad++; $display("FAIL good_hold: got %h, required a5", data); end
    endtask

    task automatic test_back_to_back();
        int left, v0;
        v0 = valid_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, CPB, 1'b1);
        send_frame(8'hFF, CPB, 1'b1);
        wait_drain(left);
        n_cmp++; if (left != 0) begin n_bad++; $display("FAIL b2b_pending: %0d frames outstanding, required 0", left); end
        n_cmp++; if (valid_cnt - v0 != 2) begin n_bad++; $display("FAIL b2b_valid_count: got %0d, required 2", valid_cnt - v0); end
    endtask

    task automatic test_glitch();
        int v0;
        v0 = valid_cnt;
        @(posedge clk);
        #1;
        drive_bit(1'b0, 5);
        rxd = 1'b1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_high: got %b, required 1", busy); end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_low: got %b, required 0", busy); end
        n_cmp++; if (data !== 8'hFF) begin n_bad++; $display("FAIL glitch_data: got %h, required ff", data); end
        n_cmp++; if (valid_cnt != v0) begin n_bad++; $display("FAIL glitch_valid: got %0d pulses, required 0", valid_cnt - v0); end
    endtask

    task automatic test_frame_err();
        int left, v0, f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, CPB, 1'b0);
        drive_bit(1'b0, 40);
        n_cmp++; if (ferr_cnt - f0 != 1) begin n_bad++; $display("FAIL ferr_count: got %0d pulses, required 1", ferr_cnt - f0); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ferr_wait_high: busy=%b, required 1", busy); end
        n_cmp++; if (data !== 8'hFF) begin n_bad++; $display("FAIL ferr_data_kept: got %h, required ff", data); end
        n_cmp++; if (valid_cnt != v0) begin n_bad++; $display("FAIL ferr_valid: got %0d pulses, required 0", valid_cnt - v0); end
        drive_bit(1'b1, 10);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_release: busy=%b, required 0", busy); end
        exp_q.push_back(8'h81);
        send_frame(8'h81, CPB, 1'b1);
        wait_drain(left);
        n_cmp++; if (left != 0) begin n_bad++; $display("FAIL ferr_next_pending: %0d frames outstanding, required 0", left); end
        n_cmp++; if (ferr_cnt - f0 != 1) begin n_bad++; $display("FAIL ferr_total: got %0d pulses, required 1", ferr_cnt - f0); end
    endtask

    task automatic test_reset_mid();
        int left, v0, f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        fork
            send_frame(8'h5A, CPB, 1'b1);
            begin
                repeat (5 * CPB + 9) @(posedge clk);
                #3;
                rst = 1'b1;
                #1;
                n_cmp++; if (data !== 8'h00)     begin n_bad++; $display("FAIL rstmid_data: got %h, required 00", data); end
                n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
                n_cmp++; if (valid !== 1'b0)     begin n_bad++; $display("FAIL rstmid_valid: got %b, required 0", valid); end
                n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_frame_err: got %b, required 0", frame_err); end
            end
        join
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: busy=%b, required 0", busy); end
        n_cmp++; if (valid_cnt != v0 || ferr_cnt != f0) begin
            n_bad++; $display("FAIL rstmid_pulses: valid %0d frame_err %0d, required 0 0", valid_cnt - v0, ferr_cnt - f0);
        end
        exp_q.push_back(8'h12);
        send_frame(8'h12, CPB, 1'b1);
        wait_drain(left);
        n_cmp++; if (left != 0) begin n_bad++; $display("FAIL rstmid_next_pending: %0d frames outstanding, required 0", left); end
    endtask

    task automatic test_baud_tolerance();
        int left;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, CPB + 1, 1'b1);
        wait_drain(left);
        n_cmp++; if (left != 0 || data !== 8'hC3) begin n_bad++; $display("FAIL baud_slow: data %h pending %0d, required c3 0", data, left); end
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, CPB - 1, 1'b1);
        wait_drain(left);
        n_cmp++; if (left != 0 || data !== 8'hC3) begin n_bad++; $display("FAIL baud_fast: data %h pending %0d, required c3 0", data, left); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_baud_tolerance();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
